// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
//   alu_op_e  : 2-bit operation select encoding (ADD, SUB, AND, OR)
//   ALU_WIDTH : default operand/result width
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor.
//   a, b     : operands
//   sub      : 0 -> a + b, 1 -> a + ~b + 1
//   sum      : WIDTH-bit result (modulo 2^WIDTH)
//   carry    : carry out of the top bit (for SUB: 1 means no borrow)
//   overflow : signed overflow of the operation
module alu_addsub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full_sum;

    always_comb begin
        b_eff    = sub ? ~b : b;
        full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        sum      = full_sum[WIDTH-1:0];
        carry    = full_sum[WIDTH];
        // Same-sign effective operands whose sum flips sign; with b inverted
        // this also covers the SUB rule (A, B of different signs).
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (full_sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu.sv
// Registered integer ALU for the execute stage.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, clears all outputs
//   data1_i    : operand A
//   data2_i    : operand B
//   AluOp_i    : operation select (alu_op_e)
//   result_o   : registered result
//   zero_o     : registered flag, result == 0
//   negative_o : registered flag, result MSB
//   carry_o    : registered carry-out (ADD) / no-borrow (SUB), 0 for logic ops
//   overflow_o : registered signed overflow, 0 for logic ops
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [1:0]       AluOp_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             negative_o,
    output logic             carry_o,
    output logic             overflow_o
);

    alu_op_e          op;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             overflow_d;

    assign op = alu_op_e'(AluOp_i);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a        (data1_i),
        .b        (data2_i),
        .sub      (op == ALU_SUB),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_overflow)
    );

    always_comb begin
        result_d   = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result_d   = as_sum;
                carry_d    = as_carry;
                overflow_d = as_overflow;
            end
            ALU_AND: result_d = data1_i & data2_i;
            ALU_OR:  result_d = data1_i | data2_i;
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o   <= '0;
            zero_o     <= 1'b0;
            negative_o <= 1'b0;
            carry_o    <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            result_o   <= result_d;
            zero_o     <= (result_d == '0);
            negative_o <= result_d[WIDTH-1];
            carry_o    <= carry_d;
            overflow_o <= overflow_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic [1:0]  AluOp_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        negative_o;
    logic        carry_o;
    logic        overflow_o;

    int total;
    int bad;

    alu #(
        .WIDTH (32)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data1_i    (data1_i),
        .data2_i    (data2_i),
        .AluOp_i    (AluOp_i),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .negative_o (negative_o),
        .carry_o    (carry_o),
        .overflow_o (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Present one operation at the falling edge, then step past the rising
    // edge that registers it so outputs can be sampled.
    task automatic apply(input logic r, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        rst_i   = r;
        AluOp_i = op;
        data1_i = a;
        data2_i = b;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 2'b00, 32'd5, 32'd3);
            total++;
            if ({result_o, zero_o, negative_o, carry_o, overflow_o} !== 36'h0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got res=%h z=%b n=%b c=%b v=%b, want all 0",
                         i, result_o, zero_o, negative_o, carry_o, overflow_o);
            end
        end
        apply(1'b0, 2'b00, 32'd5, 32'd3);
        total++;
        if (result_o !== 32'd8 || zero_o !== 1'b0 || carry_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_add: got res=%h z=%b c=%b, want res=00000008 z=0 c=0",
                     result_o, zero_o, carry_o);
        end
    endtask

    task automatic test_sub;
        apply(1'b0, 2'b01, 32'd3, 32'd5);
        total++;
        if (result_o !== 32'hFFFF_FFFE || negative_o !== 1'b1 || carry_o !== 1'b0 ||
            overflow_o !== 1'b0 || zero_o !== 1'b0) begin
            bad++;
            $display("FAIL sub_3_5: got res=%h z=%b n=%b c=%b v=%b, want fffffffe 0 1 0 0",
                     result_o, zero_o, negative_o, carry_o, overflow_o);
        end
        apply(1'b0, 2'b01, 32'd7, 32'd7);
        total++;
        if (result_o !== 32'd0 || zero_o !== 1'b1 || carry_o !== 1'b1 ||
            negative_o !== 1'b0 || overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL sub_7_7: got res=%h z=%b n=%b c=%b v=%b, want 00000000 1 0 1 0",
                     result_o, zero_o, negative_o, carry_o, overflow_o);
        end
        // most-negative minus one overflows to positive
        apply(1'b0, 2'b01, 32'h8000_0000, 32'd1);
        total++;
        if (result_o !== 32'h7FFF_FFFF || overflow_o !== 1'b1 || carry_o !== 1'b1 ||
            negative_o !== 1'b0) begin
            bad++;
            $display("FAIL sub_min_1: got res=%h n=%b c=%b v=%b, want 7fffffff 0 1 1",
                     result_o, negative_o, carry_o, overflow_o);
        end
    endtask

    task automatic test_overflow;
        apply(1'b0, 2'b00, 32'h7FFF_FFFF, 32'd1);
        total++;
        if (result_o !== 32'h8000_0000 || overflow_o !== 1'b1 || negative_o !== 1'b1 ||
            carry_o !== 1'b0 || zero_o !== 1'b0) begin
            bad++;
            $display("FAIL add_max_1: got res=%h z=%b n=%b c=%b v=%b, want 80000000 0 1 0 1",
                     result_o, zero_o, negative_o, carry_o, overflow_o);
        end
        apply(1'b0, 2'b00, 32'hFFFF_FFFF, 32'd1);
        total++;
        if (result_o !== 32'd0 || carry_o !== 1'b1 || zero_o !== 1'b1 ||
            overflow_o !== 1'b0 || negative_o !== 1'b0) begin
            bad++;
            $display("FAIL add_wrap: got res=%h z=%b n=%b c=%b v=%b, want 00000000 1 0 1 0",
                     result_o, zero_o, negative_o, carry_o, overflow_o);
        end
    endtask

    task automatic test_logic;
        apply(1'b0, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00);
        total++;
        if (result_o !== 32'hF000_F000 || carry_o !== 1'b0 || overflow_o !== 1'b0 ||
            negative_o !== 1'b1 || zero_o !== 1'b0) begin
            bad++;
            $display("FAIL and: got res=%h z=%b n=%b c=%b v=%b, want f000f000 0 1 0 0",
                     result_o, zero_o, negative_o, carry_o, overflow_o);
        end
        apply(1'b0, 2'b11, 32'h0F0F_0000, 32'h0000_00FF);
        total++;
        if (result_o !== 32'h0F0F_00FF || carry_o !== 1'b0 || overflow_o !== 1'b0 ||
            negative_o !== 1'b0) begin
            bad++;
            $display("FAIL or: got res=%h n=%b c=%b v=%b, want 0f0f00ff 0 0 0",
                     result_o, negative_o, carry_o, overflow_o);
        end
        // operands that would carry/overflow if added must still give 0 flags
        apply(1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++;
        if (result_o !== 32'hFFFF_FFFF || carry_o !== 1'b0 || overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL or_flags: got res=%h c=%b v=%b, want ffffffff 0 0",
                     result_o, carry_o, overflow_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp_res;
        logic        exp_c;
        logic        exp_v;
        longint      sa;
        longint      sb;
        longint      sr;
        for (int i = 0; i < 40; i++) begin
            a  = 32'($urandom_range(9999999, 0));
            b  = 32'($urandom_range(9999999, 0));
            op = 2'($urandom_range(3, 0));
            if (i % 7 == 3) b = a;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            exp_c = 1'b0;
            exp_v = 1'b0;
            case (op)
                2'b00: begin
                    exp_res = a + b;
                    exp_c   = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                    sr      = sa + sb;
                    exp_v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                end
                2'b01: begin
                    exp_res = a - b;
                    exp_c   = (a >= b);
                    sr      = sa - sb;
                    exp_v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
                end
                2'b10: exp_res = a & b;
                default: exp_res = a | b;
            endcase
            apply(1'b0, op, a, b);
            total++;
            if (result_o !== exp_res || zero_o !== (exp_res == 32'd0) ||
                negative_o !== exp_res[31] || carry_o !== exp_c || overflow_o !== exp_v) begin
                bad++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got res=%h z=%b n=%b c=%b v=%b, want res=%h z=%b n=%b c=%b v=%b",
                         i, op, a, b, result_o, zero_o, negative_o, carry_o, overflow_o,
                         exp_res, (exp_res == 32'd0), exp_res[31], exp_c, exp_v);
            end
        end
    endtask

    task automatic test_reset_midstream;
        apply(1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++;
        if (result_o !== 32'hFFFF_FFFE || carry_o !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_add: got res=%h c=%b, want fffffffe 1", result_o, carry_o);
        end
        apply(1'b1, 2'b00, 32'd1, 32'd1);
        total++;
        if ({result_o, zero_o, negative_o, carry_o, overflow_o} !== 36'h0) begin
            bad++;
            $display("FAIL midstream_reset: got res=%h z=%b n=%b c=%b v=%b, want all 0",
                     result_o, zero_o, negative_o, carry_o, overflow_o);
        end
        apply(1'b0, 2'b01, 32'd10, 32'd4);
        total++;
        if (result_o !== 32'd6 || carry_o !== 1'b1 || zero_o !== 1'b0 ||
            negative_o !== 1'b0 || overflow_o !== 1'b0) begin
            bad++;
            $display("FAIL after_release_sub: got res=%h z=%b n=%b c=%b v=%b, want 00000006 0 0 1 0",
                     result_o, zero_o, negative_o, carry_o, overflow_o);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_i   = 1'b1;
        data1_i = '0;
        data2_i = '0;
        AluOp_i = '0;
        test_reset();
        test_sub();
        test_overflow();
        test_logic();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- Registered 32-bit integer ALU for the RISC-V core's execute stage.
- Computes one of four operations on two operands, selected by a 2-bit op code.
- Registers the result and status flags on the next rising clock edge.
- Purely datapath: no handshake; it accepts new operands every cycle.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B.
- AluOp_i  input  2  operation select.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  registered flag: result == 0.
- negative_o  output  1  registered flag: result MSB.
- carry_o  output  1  registered carry-out (ADD) / no-borrow (SUB).
- overflow_o  output  1  registered signed overflow.

Behaviour:
- Clocking and reset:
  - One clock, clk_i.
  - rst_i is sampled on the rising edge; reset is synchronous and active-high, and takes priority over all other inputs.
  - While rst_i is high at an edge, all outputs are 0 at that edge, including zero_o.
- Op encoding:
  - 00 ADD: A+B.
  - 01 SUB: A-B, computed as A + ~B + 1.
  - 10 AND: A&B.
  - 11 OR: A|B.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Throughput: one operation per cycle. Outputs hold until the next edge.
- Arithmetic: modulo 2^WIDTH wrap-around; no saturation.
- carry_o:
  - ADD: bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB: carry out of A + ~B + 1, so 1 means no borrow (A >= B unsigned).
- overflow_o:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
- AND/OR: carry_o = 0 and overflow_o = 0.
- zero_o and negative_o are derived from the computed result for every op.
- Outputs carry no X: any op value decodes to one of the four ops (full case).
- Reset mid-stream: an operation presented in a cycle where rst_i is high is discarded. The first operation after rst_i deasserts produces its result one cycle later as normal.

Decomposition:
- Package alu_pkg:
  - Enum alu_op_e: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - Constant ALU_WIDTH=32.
- One sub-module, alu_addsub:
  - Combinational WIDTH-bit adder/subtractor with a sub-select input.
  - Outputs: sum, carry and overflow.
- The top-level alu holds the op mux, flag logic and output registers.

Test Plan:
- Reset: hold rst_i for 2 cycles with nonzero inputs -> all outputs 0. Deassert rst_i with ADD 5+3 -> next cycle result 8, zero_o 0, carry_o 0.
- SUB 3-5 -> result 0xFFFFFFFE, negative_o 1, carry_o 0, overflow_o 0. SUB 7-7 -> result 0, zero_o 1, carry_o 1.
- Overflow and wrap-around:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow_o 1, negative_o 1, carry_o 0.
  - ADD 0xFFFFFFFF+1 -> 0, carry_o 1, zero_o 1, overflow_o 0.
- Logic ops:
  - AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000, carry_o 0, overflow_o 0.
  - OR 0x0F0F0000 | 0x000000FF -> 0x0F0F00FF.
- Back-to-back: change operands and op every cycle with random values in 0..9999999 -> each result matches a reference model exactly one cycle later.
- Reset mid-stream: assert rst_i in a cycle presenting ADD 1+1 -> outputs 0 after that edge. The next op after release is computed normally.
